// File: rtl/operand_bypass_pkg.sv
// Shared types and constants for the decode-to-execute operand bypass stage.
// Operand types, forwarding selects and shadow slot layout.
package operand_bypass_pkg;

    localparam int XLEN   = 32;
    localparam int RSEL_W = 3;

    typedef enum logic [1:0] {
        TYPE_IDLE = 2'd0,
        TYPE_ALU  = 2'd1,
        TYPE_LD   = 2'd2
    } op_type_e;

    localparam logic [RSEL_W-1:0] SEL_RF      = 3'd0;
    localparam logic [RSEL_W-1:0] SEL_EX2     = 3'd1;
    localparam logic [RSEL_W-1:0] SEL_MEM1    = 3'd2;
    localparam logic [RSEL_W-1:0] SEL_MEM2    = 3'd3;
    localparam logic [RSEL_W-1:0] SEL_MEM3    = 3'd4;
    localparam logic [RSEL_W-1:0] SEL_WB      = 3'd5;
    localparam logic [RSEL_W-1:0] SEL_WRITTEN = 3'd6;

    typedef struct packed {
        logic [XLEN-1:0] value;
        logic [1:0]      rtype;
    } slot_t;

endpackage

// File: rtl/operand_bypass_stage_shadow.sv
// Shadow copy of in-flight results from MEM1 through WRITTEN.
// Index 0 = MEM1 ... index 4 = WRITTEN.
module bypass_shadow_pipe
    import operand_bypass_pkg::*;
(
    input  logic            CLK,
    input  logic            RST,
    input  logic            ADVANCE,
    input  logic            SQUASH,
    input  logic [XLEN-1:0] EX2_RESULT,
    input  logic [1:0]      EX2_RD_TYPE,
    input  logic [XLEN-1:0] LOAD_DATA,
    output slot_t [4:0]     SLOTS
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            SLOTS <= '0;
        end else if (ADVANCE) begin
            if (SQUASH) begin
                SLOTS[0] <= '{value: '0, rtype: TYPE_IDLE};
            end else begin
                SLOTS[0] <= '{value: EX2_RESULT, rtype: EX2_RD_TYPE};
            end
            SLOTS[1] <= SLOTS[0];
            // load data returns as the load moves from MEM2 into MEM3
            SLOTS[2].rtype <= SLOTS[1].rtype;
            SLOTS[2].value <= (SLOTS[1].rtype == TYPE_LD)
                            ? LOAD_DATA : SLOTS[1].value;
            SLOTS[3] <= SLOTS[2];
            SLOTS[4] <= SLOTS[3];
        end
    end

endmodule

// File: rtl/operand_bypass_stage.sv
// ID/EX boundary: operand forwarding muxes, issue/bubble/squash control
// and the ID/EX register.
module operand_bypass_stage
    import operand_bypass_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              ADVANCE,
    input  logic              FLUSH,
    input  logic              ID_VALID,
    input  logic [XLEN-1:0]   ID_PC,
    input  logic [4:0]        ID_RD,
    input  logic [1:0]        ID_TYPE,
    input  logic              OPERANDS_READY,
    input  logic [RSEL_W-1:0] MUX1_SELECT,
    input  logic [RSEL_W-1:0] MUX2_SELECT,
    input  logic [1:0]        RS1_TYPE,
    input  logic [1:0]        RS2_TYPE,
    input  logic [XLEN-1:0]   RF_RS1,
    input  logic [XLEN-1:0]   RF_RS2,
    input  logic [XLEN-1:0]   EX2_RESULT,
    input  logic [1:0]        EX2_RD_TYPE,
    input  logic [XLEN-1:0]   LOAD_DATA,
    output logic              EX_VALID,
    output logic [XLEN-1:0]   EX_PC,
    output logic [4:0]        EX_RD,
    output logic [1:0]        EX_TYPE,
    output logic [XLEN-1:0]   EX_OP1,
    output logic [XLEN-1:0]   EX_OP2,
    output logic              ID_HOLD
);

    slot_t [4:0]     slots;
    logic            pend_sq;
    logic            squash;
    logic            rdy1;
    logic            rdy2;
    logic            cap;
    logic            bub;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;

    function automatic logic [XLEN-1:0] fwd(
        input logic [RSEL_W-1:0] sel,
        input logic [XLEN-1:0]   rf,
        input logic [XLEN-1:0]   ex2,
        input slot_t [4:0]       s
    );
        case (sel)
            SEL_EX2:     fwd = ex2;
            SEL_MEM1:    fwd = s[0].value;
            SEL_MEM2:    fwd = s[1].value;
            SEL_MEM3:    fwd = s[2].value;
            SEL_WB:      fwd = s[3].value;
            SEL_WRITTEN: fwd = s[4].value;
            default:     fwd = rf;
        endcase
    endfunction

    // a load producer has no data until it reaches MEM3
    function automatic logic src_rdy(
        input logic              all_rdy,
        input logic [RSEL_W-1:0] sel,
        input logic [1:0]        rtype
    );
        src_rdy = all_rdy && !(rtype == TYPE_LD
                  && sel >= SEL_EX2 && sel <= SEL_MEM2);
    endfunction

    assign squash = FLUSH || pend_sq;
    assign rdy1   = src_rdy(OPERANDS_READY, MUX1_SELECT, RS1_TYPE);
    assign rdy2   = src_rdy(OPERANDS_READY, MUX2_SELECT, RS2_TYPE);
    assign op1    = fwd(MUX1_SELECT, RF_RS1, EX2_RESULT, slots);
    assign op2    = fwd(MUX2_SELECT, RF_RS2, EX2_RESULT, slots);

    bypass_shadow_pipe u_shadow (
        .CLK         (CLK),
        .RST         (RST),
        .ADVANCE     (ADVANCE),
        .SQUASH      (squash),
        .EX2_RESULT  (EX2_RESULT),
        .EX2_RD_TYPE (EX2_RD_TYPE),
        .LOAD_DATA   (LOAD_DATA),
        .SLOTS       (slots)
    );

    always_comb begin
        cap     = 1'b0;
        bub     = 1'b0;
        ID_HOLD = 1'b0;
        unique case (1'b1)
            !ADVANCE: ID_HOLD = 1'b1;
            ADVANCE && squash: ;
            ADVANCE && !squash && ID_VALID && rdy1 && rdy2:
                cap = 1'b1;
            ADVANCE && !squash && ID_VALID && !(rdy1 && rdy2): begin
                bub     = 1'b1;
                ID_HOLD = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pend_sq  <= 1'b0;
            EX_VALID <= 1'b0;
            EX_PC    <= '0;
            EX_RD    <= '0;
            EX_TYPE  <= TYPE_IDLE;
            EX_OP1   <= '0;
            EX_OP2   <= '0;
        end else if (ADVANCE) begin
            pend_sq  <= 1'b0;
            EX_VALID <= cap;
            if (cap) begin
                EX_PC   <= ID_PC;
                EX_RD   <= ID_RD;
                EX_TYPE <= ID_TYPE;
                EX_OP1  <= op1;
                EX_OP2  <= op2;
            end else if (bub) begin
                EX_TYPE <= TYPE_IDLE;
            end
        end else if (FLUSH) begin
            pend_sq <= 1'b1;
        end
    end

endmodule

// File: tb/tb_operand_bypass_stage.sv
// Randomized + directed scoreboard bench for operand_bypass_stage.
// Reference model keeps in-flight results as an age-indexed array.
module tb_operand_bypass_stage;

    logic        CLK = 1'b0;
    logic        RST, ADVANCE, FLUSH, ID_VALID;
    logic [31:0] ID_PC;
    logic [4:0]  ID_RD;
    logic [1:0]  ID_TYPE;
    logic        OPERANDS_READY;
    logic [2:0]  MUX1_SELECT, MUX2_SELECT;
    logic [1:0]  RS1_TYPE, RS2_TYPE;
    logic [31:0] RF_RS1, RF_RS2, EX2_RESULT, LOAD_DATA;
    logic [1:0]  EX2_RD_TYPE;
    logic        EX_VALID, ID_HOLD;
    logic [31:0] EX_PC, EX_OP1, EX_OP2;
    logic [4:0]  EX_RD;
    logic [1:0]  EX_TYPE;

    operand_bypass_stage dut (
        .CLK(CLK), .RST(RST), .ADVANCE(ADVANCE), .FLUSH(FLUSH),
        .ID_VALID(ID_VALID), .ID_PC(ID_PC), .ID_RD(ID_RD),
        .ID_TYPE(ID_TYPE), .OPERANDS_READY(OPERANDS_READY),
        .MUX1_SELECT(MUX1_SELECT), .MUX2_SELECT(MUX2_SELECT),
        .RS1_TYPE(RS1_TYPE), .RS2_TYPE(RS2_TYPE),
        .RF_RS1(RF_RS1), .RF_RS2(RF_RS2),
        .EX2_RESULT(EX2_RESULT), .EX2_RD_TYPE(EX2_RD_TYPE),
        .LOAD_DATA(LOAD_DATA), .EX_VALID(EX_VALID), .EX_PC(EX_PC),
        .EX_RD(EX_RD), .EX_TYPE(EX_TYPE), .EX_OP1(EX_OP1),
        .EX_OP2(EX_OP2), .ID_HOLD(ID_HOLD)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          valid;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [1:0]  typ;
        logic [31:0] op1;
        logic [31:0] op2;
    } ex_t;

    ex_t         exp_q[$];
    ex_t         m_ex;
    logic [31:0] m_val[5];
    logic [1:0]  m_typ[5];
    bit          m_pend;
    bit          started = 0;
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] src(input logic [2:0] sel,
                                        input logic [31:0] rf);
        if (sel == 3'd1) return EX2_RESULT;
        if (sel >= 3'd2 && sel <= 3'd6) return m_val[sel - 3'd2];
        return rf;
    endfunction

    function automatic bit rdy(input logic [2:0] sel,
                               input logic [1:0] t);
        if (!OPERANDS_READY) return 0;
        return !(t == 2'd2 && sel >= 3'd1 && sel <= 3'd3);
    endfunction

    task automatic model_reset();
        m_ex = '{0, 32'd0, 5'd0, 2'd0, 32'd0, 32'd0};
        m_pend = 0;
        for (int i = 0; i < 5; i++) begin
            m_val[i] = '0;
            m_typ[i] = 2'd0;
        end
    endtask

    task automatic step();
        bit          ok, sq, hold;
        logic [31:0] o1, o2;
        @(negedge CLK);
        ok = rdy(MUX1_SELECT, RS1_TYPE) && rdy(MUX2_SELECT, RS2_TYPE);
        sq = FLUSH || m_pend;
        if (!ADVANCE) hold = 1;
        else if (sq) hold = 0;
        else hold = ID_VALID && !ok;
        if (!RST) chk("id_hold", {31'd0, ID_HOLD}, {31'd0, hold});
        o1 = src(MUX1_SELECT, RF_RS1);
        o2 = src(MUX2_SELECT, RF_RS2);
        if (RST) begin
            model_reset();
        end else if (!ADVANCE) begin
            if (FLUSH) m_pend = 1;
        end else begin
            m_pend = 0;
            if (!sq && ID_VALID && ok)
                m_ex = '{1, ID_PC, ID_RD, ID_TYPE, o1, o2};
            else begin
                m_ex.valid = 0;
                if (!sq && ID_VALID) m_ex.typ = 2'd0;
            end
            for (int i = 4; i >= 1; i--) begin
                m_typ[i] = m_typ[i-1];
                m_val[i] = m_val[i-1];
                if (i == 2 && m_typ[1] == 2'd2) m_val[2] = LOAD_DATA;
            end
            m_val[0] = sq ? 32'd0 : EX2_RESULT;
            m_typ[0] = sq ? 2'd0 : EX2_RD_TYPE;
        end
        exp_q.push_back(m_ex);
        started = 1;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        ex_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (started) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_underflow: no expected entry");
                end else begin
                    e = exp_q.pop_front();
                    if (EX_VALID !== e.valid || EX_PC !== e.pc ||
                        EX_RD !== e.rd || EX_TYPE !== e.typ ||
                        EX_OP1 !== e.op1 || EX_OP2 !== e.op2) begin
                        fails++;
                        $display({"FAIL ex_reg: got v=%0b pc=%h rd=%0d ",
                                  "t=%0d op1=%h op2=%h expected v=%0b ",
                                  "pc=%h rd=%0d t=%0d op1=%h op2=%h"},
                                 EX_VALID, EX_PC, EX_RD, EX_TYPE,
                                 EX_OP1, EX_OP2, e.valid, e.pc, e.rd,
                                 e.typ, e.op1, e.op2);
                    end
                end
            end
        end
    end

    task automatic idle_in();
        RST = 0; ADVANCE = 1; FLUSH = 0; ID_VALID = 0;
        ID_PC = 0; ID_RD = 0; ID_TYPE = 0; OPERANDS_READY = 1;
        MUX1_SELECT = 0; MUX2_SELECT = 0; RS1_TYPE = 0; RS2_TYPE = 0;
        RF_RS1 = 0; RF_RS2 = 0; EX2_RESULT = 0; EX2_RD_TYPE = 0;
        LOAD_DATA = 0;
    endtask

    initial begin
        model_reset();
        idle_in();
        RST = 1;
        step();
        chk("reset_valid", {31'd0, EX_VALID}, 32'd0);
        chk("reset_op1", EX_OP1, 32'd0);

        RST = 0; ID_VALID = 1; ID_PC = 32'h100; ID_RD = 5'd3;
        ID_TYPE = 2'd1; RF_RS1 = 32'd5; RF_RS2 = 32'd7;
        step();
        chk("rf_valid", {31'd0, EX_VALID}, 32'd1);
        chk("rf_op1", EX_OP1, 32'd5);
        chk("rf_op2", EX_OP2, 32'd7);

        EX2_RESULT = 32'h1234; EX2_RD_TYPE = 2'd1; MUX1_SELECT = 3'd1;
        step();
        chk("ex2_fwd", EX_OP1, 32'h1234);
        EX2_RESULT = 0; EX2_RD_TYPE = 0; MUX1_SELECT = 0;
        step();
        MUX2_SELECT = 3'd3;
        step();
        chk("mem2_fwd", EX_OP2, 32'h1234);

        MUX2_SELECT = 0; ID_VALID = 0;
        EX2_RESULT = 32'hDEAD; EX2_RD_TYPE = 2'd2;
        step();
        EX2_RESULT = 0; EX2_RD_TYPE = 0;
        ID_VALID = 1; RS1_TYPE = 2'd2; MUX1_SELECT = 3'd2;
        step();
        chk("loaduse_bubble", {31'd0, EX_VALID}, 32'd0);
        chk("loaduse_hold", {31'd0, ID_HOLD}, 32'd1);
        MUX1_SELECT = 3'd3; LOAD_DATA = 32'hBEEF;
        step();
        MUX1_SELECT = 3'd4; LOAD_DATA = 0;
        step();
        chk("load_fwd_valid", {31'd0, EX_VALID}, 32'd1);
        chk("load_fwd_op1", EX_OP1, 32'hBEEF);

        ADVANCE = 0; RF_RS1 = 32'h55; MUX1_SELECT = 0;
        repeat (3) step();
        chk("stall_op1", EX_OP1, 32'hBEEF);
        chk("stall_hold", {31'd0, ID_HOLD}, 32'd1);
        ADVANCE = 1; RS1_TYPE = 0;
        step();
        chk("resume_op1", EX_OP1, 32'h55);

        FLUSH = 1; EX2_RESULT = 32'd77; EX2_RD_TYPE = 2'd1;
        step();
        chk("flush_valid", {31'd0, EX_VALID}, 32'd0);
        FLUSH = 0; MUX1_SELECT = 3'd2;
        step();
        chk("flush_mem1_val", EX_OP1, 32'd0);
        ADVANCE = 0; FLUSH = 1;
        step();
        ADVANCE = 1; FLUSH = 0;
        step();
        chk("pend_squash", {31'd0, EX_VALID}, 32'd0);
        step();
        chk("post_squash", {31'd0, EX_VALID}, 32'd1);

        RST = 1;
        step();
        chk("midrst_valid", {31'd0, EX_VALID}, 32'd0);
        chk("midrst_pc", EX_PC, 32'd0);
        chk("midrst_op2", EX_OP2, 32'd0);

        for (int n = 0; n < 3000; n++) begin
            RST = ($urandom_range(0, 99) < 2);
            ADVANCE = ($urandom_range(0, 99) < 80);
            FLUSH = ($urandom_range(0, 99) < 10);
            ID_VALID = ($urandom_range(0, 99) < 85);
            ID_PC = $urandom;
            ID_RD = 5'($urandom);
            ID_TYPE = 2'($urandom_range(0, 2));
            OPERANDS_READY = ($urandom_range(0, 99) < 85);
            MUX1_SELECT = 3'($urandom);
            MUX2_SELECT = 3'($urandom);
            RS1_TYPE = 2'($urandom_range(0, 2));
            RS2_TYPE = 2'($urandom_range(0, 2));
            RF_RS1 = $urandom;
            RF_RS2 = $urandom;
            EX2_RESULT = $urandom;
            EX2_RD_TYPE = 2'($urandom_range(0, 2));
            LOAD_DATA = $urandom;
            step();
        end

        #3;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: got %0d entries expected 0",
                     exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/operand_bypass_stage.md
# operand_bypass_stage

Decode-to-execute boundary stage of the RISC-V pipeline. It consumes the per-operand forwarding selects, operand types and ready flag produced by the register-state scoreboard. It keeps a shadow pipeline of in-flight result values (EX2 through "written") and latches the two resolved operands plus instruction tag into the ID/EX register. It inserts bubbles when operands are not ready, holds on cache stalls, and squashes younger results on FLUSH.

## Interface
- XLEN, 32, datapath width
- RSEL_W, 3, forwarding-select width
- CLK  in  1  clock
- RST  in  1  reset; synchronous, active-high
- ADVANCE  in  1  pipeline may move (data and instruction caches both ready)
- FLUSH  in  1  branch/exception squash
- ID_VALID  in  1  decode holds a valid instruction
- ID_PC  in  XLEN  decode PC
- ID_RD  in  5  destination register
- ID_TYPE  in  2  idle/alu/ld (shared encoding)
- OPERANDS_READY  in  1  scoreboard ready flag (1 = both sources available)
- MUX1_SELECT, MUX2_SELECT  in  RSEL_W  source select per operand
- RS1_TYPE, RS2_TYPE  in  2  producer type per operand
- RF_RS1, RF_RS2  in  XLEN  register-file read data
- EX2_RESULT  in  XLEN  ALU result leaving EX2
- EX2_RD_TYPE  in  2  type of instruction in EX2 (idle = no result)
- LOAD_DATA  in  XLEN  load data valid at MEM3 slot
- EX_VALID  out  1  ID/EX register holds an instruction
- EX_PC  out  XLEN
- EX_RD  out  5
- EX_TYPE  out  2
- EX_OP1, EX_OP2  out  XLEN  resolved operands
- ID_HOLD  out  1  decode must not advance this cycle

## Operation
- Select encoding: 0 = RF, 1 = EX2, 2 = MEM1, 3 = MEM2, 4 = MEM3, 5 = WB, 6 = WRITTEN, 7 = reserved (treated as RF).
- Shadow pipeline: slots MEM1, MEM2, MEM3, WB and WRITTEN, each holding {value, type}.
  - Shifts only when ADVANCE=1.
  - MEM1 ← {EX2_RESULT, EX2_RD_TYPE}; MEM2 ← MEM1.
  - MEM3 ← MEM2, except value = LOAD_DATA when the MEM2 type is ld.
  - WB ← MEM3; WRITTEN ← WB.
- Operand mux: selected source is RF, EX2_RESULT, or the matching shadow slot value.
- Readiness: an operand is not ready when OPERANDS_READY=0, or when its RSx_TYPE=ld and its select is 1..3 (load data not yet returned).
- Issue, evaluated when ADVANCE=1:
  - FLUSH=1: EX_VALID ← 0; MEM1 type ← idle (EX2 value discarded, EX2/MEM1 squashed); ID_HOLD=0.
  - Else ID_VALID & both ready: capture PC/RD/TYPE/OP1/OP2; EX_VALID ← 1; ID_HOLD=0.
  - Else ID_VALID & not ready: bubble (EX_VALID ← 0, EX_TYPE ← idle); ID_HOLD=1.
  - Else (no valid instruction): EX_VALID ← 0; ID_HOLD=0.
- ADVANCE=0: all registers hold; ID_HOLD=1.
- Squash: FLUSH with ADVANCE=0 is latched as a pending squash, applied on the next ADVANCE=1 cycle.

## Timing
- Reset: EX_VALID=0, EX_PC=0, EX_RD=0, EX_TYPE=idle, EX_OP1=EX_OP2=0, all shadow slots {0, idle}, pending squash 0.
- ID_HOLD is combinational from the current inputs; all other outputs are registered with one-cycle latency from ID to EX.
- The forwarding value is sampled in the same cycle as the select; there is no extra delay.
- FLUSH together with a ready instruction: the flush wins and no capture occurs.
- RST together with any other input: reset wins.
- WB/WRITTEN values persist until overwritten by shifting; they are not cleared by FLUSH.

## Structure
- Shared package holds: ID_TYPE encoding (idle/alu/ld), the forwarding-select constants (SEL_RF…SEL_WRITTEN), and XLEN.
- One sub-module, bypass_shadow_pipe: the slot shift register with load-data insertion and squash. The top level holds the operand muxes, the issue logic and the ID/EX register.

## Test plan
- Reset, then RF-only ALU instruction: RST 1 cycle; ID_VALID=1, selects=0, RF_RS1=5, RF_RS2=7, ADVANCE=1 → next cycle EX_VALID=1, EX_OP1=5, EX_OP2=7.
- Back-to-back ALU forwarding: EX2_RESULT=0x1234 with MUX1_SELECT=1 → EX_OP1=0x1234; two ADVANCE cycles later, MUX2_SELECT=3 → EX_OP2=0x1234.
- Load-use: RS1_TYPE=ld, MUX1_SELECT=2 → bubble (EX_VALID=0), ID_HOLD=1; after LOAD_DATA=0xBEEF reaches MEM3 with MUX1_SELECT=4 → EX_OP1=0xBEEF.
- Cache stall: ADVANCE=0 for 3 cycles mid-sequence → all EX outputs and shadow slots unchanged, ID_HOLD=1; resumes correctly afterwards.
- Flush: FLUSH=1 with ADVANCE=1 and a ready instruction → EX_VALID=0, MEM1 type idle; FLUSH during ADVANCE=0 → squash applied on the first ADVANCE=1 cycle.
- Reset mid-operation: RST asserted while EX_VALID=1 and slots populated → next cycle all outputs at reset values.
